// File: rtl/sram_pkg.sv
// Shared types, collision-mode codes and the byte-lane merge helper for the
// parametrised 1RW+1R SRAM.
package sram_pkg;

  localparam int COLL_READ_OLD   = 0;
  localparam int COLL_WRITE_THRU = 1;

  // Merge helper works on a fixed wide word; callers cast in and out.
  localparam int MERGE_W      = 256;
  localparam int MERGE_MASK_W = MERGE_W / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } sram_state_t;

  function automatic logic [MERGE_W-1:0] merge_bytes(
    input logic [MERGE_W-1:0]      old_word,
    input logic [MERGE_W-1:0]      new_word,
    input logic [MERGE_MASK_W-1:0] mask
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_MASK_W; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: carries data, valid and collision tag for 1 or 2
// cycles; data holds its last value between reads.
module sram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_coll,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_coll
);

  logic [DATA_WIDTH-1:0] s1_data_r;
  logic                  s1_valid_r;
  logic                  s1_coll_r;

  // First stage: capture array read data on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_r  <= {DATA_WIDTH{1'b0}};
      s1_valid_r <= 1'b0;
      s1_coll_r  <= 1'b0;
    end else begin
      s1_valid_r <= in_valid;
      s1_coll_r  <= in_valid & in_coll;
      if (in_valid) begin
        s1_data_r <= in_data;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_data_r;
      logic                  s2_valid_r;
      logic                  s2_coll_r;

      // Second stage: one extra cycle of latency, still one result per cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data_r  <= {DATA_WIDTH{1'b0}};
          s2_valid_r <= 1'b0;
          s2_coll_r  <= 1'b0;
        end else begin
          s2_valid_r <= s1_valid_r;
          s2_coll_r  <= s1_coll_r;
          if (s1_valid_r) begin
            s2_data_r <= s1_data_r;
          end
        end
      end

      assign out_data  = s2_data_r;
      assign out_valid = s2_valid_r;
      assign out_coll  = s2_coll_r;
    end else begin : g_lat1
      assign out_data  = s1_data_r;
      assign out_valid = s1_valid_r;
      assign out_coll  = s1_coll_r;
    end
  endgenerate

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW + 1R SRAM with byte write masks, 1/2-cycle read latency,
// defined same-address collision behaviour and a post-reset hardware clear.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int NUM_WMASK      = DATA_WIDTH / 8,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASK-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  sram_state_t           state_r;
  sram_state_t           state_nxt_s;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;
  logic [ADDR_WIDTH-1:0] clr_cnt_nxt_s;
  logic                  busy_s;
  logic                  clr_we_s;
  logic                  wr_acc_s;
  logic                  rd0_acc_s;
  logic                  rd1_acc_s;
  logic                  coll_s;
  logic [DATA_WIDTH-1:0] merged_s;
  logic [DATA_WIDTH-1:0] rd0_data_s;
  logic [DATA_WIDTH-1:0] rd1_data_s;
  logic                  coll0_unused_s;

  // Clear FSM state and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Clear FSM next state: zero one word per cycle, then serve requests.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    busy_s        = 1'b0;
    clr_we_s      = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        busy_s   = 1'b1;
        clr_we_s = ~rst;
        if (clr_cnt_r == ADDR_WIDTH'(DEPTH - 1)) begin
          state_nxt_s   = ST_IDLE;
          clr_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
        end else begin
          clr_cnt_nxt_s = clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        clr_cnt_nxt_s = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  assign busy = busy_s;

  // An all-zero mask is a no-op write, so it also never counts as a collision.
  assign wr_acc_s  = ~rst & ~busy_s & ~csb0 & ~web0 & (wmask0 != {NUM_WMASK{1'b0}});
  assign rd0_acc_s = ~rst & ~busy_s & ~csb0 & web0;
  assign rd1_acc_s = ~rst & ~busy_s & ~csb1;
  assign coll_s    = wr_acc_s & rd1_acc_s & (addr0 == addr1);

  assign merged_s = DATA_WIDTH'(merge_bytes(MERGE_W'(mem_r[addr0]),
                                            MERGE_W'(din0),
                                            MERGE_MASK_W'(wmask0)));
  assign rd0_data_s = mem_r[addr0];

  // Port1 read source: write-through mode forwards the merged word on collision.
  always_comb begin
    rd1_data_s = mem_r[addr1];
    if ((COLLISION_MODE == COLL_WRITE_THRU) && coll_s) begin
      rd1_data_s = merged_s;
    end else begin
      rd1_data_s = mem_r[addr1];
    end
  end

  // Array write port: clear sequence has priority, requests are gated by busy.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
    end else if (wr_acc_s) begin
      mem_r[addr0] <= merged_s;
    end
  end

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd0_acc_s),
    .in_data  (rd0_data_s),
    .in_coll  (1'b0),
    .out_data (dout0),
    .out_valid(dout0_valid),
    .out_coll (coll0_unused_s)
  );

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd1_acc_s),
    .in_data  (rd1_data_s),
    .in_coll  (coll_s),
    .out_data (dout1),
    .out_valid(dout1_valid),
    .out_coll (collision)
  );

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Directed bench: two instances share stimulus, A = (L=1, read-old),
// B = (L=2, write-through); expected values are hand-computed constants.
module tb_sram_1rw1r_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0, addr0, addr1;
  logic [31:0] din0;

  logic        busy_a, v0_a, v1_a, coll_a;
  logic        busy_b, v0_b, v1_b, coll_b;
  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_1rw1r_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_WMASK(4), .READ_LATENCY(1),
    .COLLISION_MODE(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst(rst), .busy(busy_a),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0_a), .dout0_valid(v0_a),
    .csb1(csb1), .addr1(addr1), .dout1(dout1_a), .dout1_valid(v1_a),
    .collision(coll_a)
  );

  sram_1rw1r_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_WMASK(4), .READ_LATENCY(2),
    .COLLISION_MODE(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst(rst), .busy(busy_b),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0_b), .dout0_valid(v0_b),
    .csb1(csb1), .addr1(addr1), .dout1(dout1_b), .dout1_valid(v1_b),
    .collision(coll_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = 4'h0;
    csb1   = 1'b1;
  endtask

  task automatic wr0(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    tick();
    idle();
  endtask

  // Releases reset, issues write/read requests while busy, returns busy length.
  task automatic clear_with_requests(output int busy_cnt, output int busy_b_cnt, output logic any_v);
    busy_cnt = 0;
    busy_b_cnt = 0;
    any_v = 1'b0;
    rst  = 1'b0;
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd9; din0 = 32'h0000_0055; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 4'd9;
    while (busy_a && busy_cnt < 40) begin
      busy_cnt++;
      if (busy_b) busy_b_cnt++;
      any_v = any_v | v0_a | v1_a | v0_b | v1_b;
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      any_v = any_v | v0_a | v1_a | v0_b | v1_b;
      tick();
    end
  endtask

  logic [31:0] tp_data [3];
  logic        exp_va  [5];
  logic [31:0] exp_da  [5];
  logic        exp_vb  [5];
  logic [31:0] exp_db  [5];
  int          bcnt, bcnt_b;
  logic        anyv;

  initial begin
    rst = 1'b1;
    addr0 = 4'd0; addr1 = 4'd0; din0 = 32'd0;
    idle();
    tick();
    tick();
    check("rst_dout0", dout0_a, 32'h0);
    check("rst_dout1", dout1_b, 32'h0);
    check("rst_valids", {28'd0, v0_a, v1_a, v0_b, v1_b}, 32'h0);
    check("rst_coll", {30'd0, coll_a, coll_b}, 32'h0);

    // Clear after reset, with requests attempted while busy.
    clear_with_requests(bcnt, bcnt_b, anyv);
    check("clear_busy_len_a", 32'(bcnt), 32'd16);
    check("clear_busy_len_b", 32'(bcnt_b), 32'd16);
    check("busy_no_valid", 32'(anyv), 32'd0);
    check("idle_busy", {30'd0, busy_a, busy_b}, 32'h0);

    // Port1 sweep of every address: all zero (includes busy-gated addr 9).
    for (int n = 0; n <= 17; n++) begin
      if (n >= 1 && n <= 16) check($sformatf("clr_rd_a_%0d", n - 1), {v1_a, dout1_a[30:0]}, 32'h8000_0000);
      if (n >= 2) check($sformatf("clr_rd_b_%0d", n - 2), {v1_b, dout1_b[30:0]}, 32'h8000_0000);
      if (n < 16) begin
        csb1 = 1'b0; addr1 = 4'(n);
      end else begin
        csb1 = 1'b1;
      end
      tick();
    end

    // Byte-masked writes, plus a no-op write with an empty mask.
    wr0(4'd0, 32'hA0A0_A0A0, 4'hF);
    wr0(4'd1, 32'hB1B1_B1B1, 4'hF);
    wr0(4'd2, 32'hC2C2_C2C2, 4'hF);
    wr0(4'd3, 32'h1122_3344, 4'hF);
    wr0(4'd3, 32'hAABB_CCDD, 4'h5);
    wr0(4'd3, 32'hFFFF_FFFF, 4'h0);
    check("noop_no_valid", {28'd0, v0_a, v1_a, v0_b, v1_b}, 32'h0);

    // Port0 read of addr 3: A valid after 1 edge, B after 2, single pulses.
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3;
    tick();
    idle();
    check("mask_rd_a", dout0_a, 32'h11BB_33DD);
    check("mask_lat_k1", {30'd0, v0_a, v0_b}, 32'h2);
    tick();
    check("mask_rd_b", dout0_b, 32'h11BB_33DD);
    check("mask_lat_k2", {30'd0, v0_a, v0_b}, 32'h1);
    tick();
    check("mask_pulse_end", {30'd0, v0_a, v0_b}, 32'h0);
    check("mask_hold_b", dout0_b, 32'h11BB_33DD);

    // Back-to-back port1 reads of addresses 0,1,2.
    tp_data[0] = 32'hA0A0_A0A0; tp_data[1] = 32'hB1B1_B1B1; tp_data[2] = 32'hC2C2_C2C2;
    exp_va = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_da = '{tp_data[0], tp_data[1], tp_data[2], tp_data[2], tp_data[2]};
    exp_vb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_db = '{32'h0, tp_data[0], tp_data[1], tp_data[2], tp_data[2]};
    for (int k = 0; k < 3; k++) begin
      csb1 = 1'b0; addr1 = 4'(k);
      tick();
      check($sformatf("tp_va_%0d", k), 32'(v1_a), 32'(exp_va[k]));
      check($sformatf("tp_da_%0d", k), dout1_a, exp_da[k]);
      check($sformatf("tp_vb_%0d", k), 32'(v1_b), 32'(exp_vb[k]));
      if (k >= 1) check($sformatf("tp_db_%0d", k), dout1_b, exp_db[k]);
    end
    idle();
    for (int k = 3; k < 5; k++) begin
      tick();
      check($sformatf("tp_va_%0d", k), 32'(v1_a), 32'(exp_va[k]));
      check($sformatf("tp_da_%0d", k), dout1_a, exp_da[k]);
      check($sformatf("tp_vb_%0d", k), 32'(v1_b), 32'(exp_vb[k]));
      check($sformatf("tp_db_%0d", k), dout1_b, exp_db[k]);
    end

    // Collision on addr 5 (holds 0): A returns old data, B the written word.
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5; din0 = 32'hDEAD_BEEF; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 4'd5;
    tick();
    idle();
    check("coll_a_flags", {30'd0, v1_a, coll_a}, 32'h3);
    check("coll_a_data", dout1_a, 32'h0);
    check("coll_b_early", {30'd0, v1_b, coll_b}, 32'h0);
    tick();
    check("coll_b_flags", {30'd0, v1_b, coll_b}, 32'h3);
    check("coll_b_data", dout1_b, 32'hDEAD_BEEF);
    check("coll_a_end", {30'd0, v1_a, coll_a}, 32'h0);
    csb1 = 1'b0; addr1 = 4'd5;
    tick();
    idle();
    check("post_coll_a", dout1_a, 32'hDEAD_BEEF);
    check("post_coll_a_flag", 32'(coll_a), 32'h0);
    tick();
    check("post_coll_b", dout1_b, 32'hDEAD_BEEF);
    check("post_coll_b_flag", 32'(coll_b), 32'h0);

    // Reset mid-clear: reset, run 7 clear cycles, reset again.
    check("hold_dout0", dout0_a, 32'h11BB_33DD);
    rst = 1'b1;
    tick();
    check("rst2_dout0", dout0_a, 32'h0);
    rst = 1'b0;
    repeat (7) tick();
    check("mid_clear_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    tick();
    clear_with_requests(bcnt, bcnt_b, anyv);
    check("restart_busy_len", 32'(bcnt), 32'd16);
    check("restart_no_valid", 32'(anyv), 32'd0);

    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3;
    csb1 = 1'b0; addr1 = 4'd9;
    tick();
    idle();
    check("restart_rd3_a", {v0_a, dout0_a[30:0]}, 32'h8000_0000);
    check("restart_rd9_a", {v1_a, dout1_a[30:0]}, 32'h8000_0000);
    tick();
    check("restart_rd9_b", {v1_b, dout1_b[30:0]}, 32'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
